// File: rtl/cpu_regfile_pkg.sv
// -----------------------------------------------------------------------------
// cpu_regfile_pkg
// Shared definitions for the moxie multi-port register file: default geometry,
// the register index type and the index range qualifier used by writes, marks
// and reads alike.
// -----------------------------------------------------------------------------
package cpu_regfile_pkg;

    localparam int REGF_DATA_W   = 32;
    localparam int REGF_NUM_REGS = 16;
    localparam int REGF_ADDR_W   = $clog2(REGF_NUM_REGS);

    typedef logic [REGF_ADDR_W-1:0] regidx_t;

    // An index addresses real storage only if it is below num_regs. When r0 is
    // hardwired to zero it is treated as out of range, so writes and marks to
    // it are dropped and reads fall through to the zero path.
    function automatic logic in_range(input logic [31:0] idx,
                                      input int          num_regs,
                                      input logic        zero_r0);
        return (idx < 32'(num_regs)) && !(zero_r0 && (idx == 32'd0));
    endfunction

endpackage

// File: rtl/cpu_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// cpu_regfile_scoreboard
// One pending bit per architectural register. A load issue (set) marks its
// destination busy; the load writeback (clear) releases it. When both hit the
// same register in one cycle the set wins, because a newer load is in flight.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_n_i     asynchronous active-low reset, clears all pending bits
//   set_i       set pending bit of set_idx_i (already range-qualified)
//   set_idx_i   register to mark
//   clr_i       clear pending bit of clr_idx_i (already range-qualified)
//   clr_idx_i   register to release
//   busy_vec_o  registered pending bits
// -----------------------------------------------------------------------------
module cpu_regfile_scoreboard
    import cpu_regfile_pkg::*;
#(
    parameter int NUM_REGS = REGF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                set_i,
    input  logic [ADDR_W-1:0]   set_idx_i,
    input  logic                clr_i,
    input  logic [ADDR_W-1:0]   clr_idx_i,
    output logic [NUM_REGS-1:0] busy_vec_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_vec_o <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (set_i && (set_idx_i == ADDR_W'(i))) begin
                    busy_vec_o[i] <= 1'b1;
                end else if (clr_i && (clr_idx_i == ADDR_W'(i))) begin
                    busy_vec_o[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/cpu_regfile_mp.sv
// -----------------------------------------------------------------------------
// cpu_regfile_mp
// Multi-port register file for the moxie core. Two write ports (0 = ALU
// writeback, 1 = load writeback), NUM_RD combinational read ports with optional
// same-cycle write bypass, and a per-register pending scoreboard for load-use
// hazard detection in decode.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   we0_i/widx0_i/wdata0_i   ALU write port; wins data on an index clash
//   we1_i/widx1_i/wdata1_i   load write port; also clears the pending bit
//   mark_i/mark_idx_i        mark a register pending (load issued)
//   rd_idx_i     packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   rd_data_o    packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy_o    pending bit seen by each read port
//   busy_vec_o   all pending bits, registered
//   collision_o  one-cycle pulse after both write ports hit the same index
// -----------------------------------------------------------------------------
module cpu_regfile_mp
    import cpu_regfile_pkg::*;
#(
    parameter int                DATA_W    = REGF_DATA_W,
    parameter int                NUM_REGS  = REGF_NUM_REGS,
    parameter int                ADDR_W    = $clog2(NUM_REGS),
    parameter int                NUM_RD    = 2,
    parameter int                BYPASS    = 1,
    parameter int                ZERO_R0   = 0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     we0_i,
    input  logic [ADDR_W-1:0]        widx0_i,
    input  logic [DATA_W-1:0]        wdata0_i,
    input  logic                     we1_i,
    input  logic [ADDR_W-1:0]        widx1_i,
    input  logic [DATA_W-1:0]        wdata1_i,
    input  logic                     mark_i,
    input  logic [ADDR_W-1:0]        mark_idx_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_idx_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    output logic [NUM_REGS-1:0]      busy_vec_o,
    output logic                     collision_o
);

    localparam logic ZR0 = (ZERO_R0 != 0);
    localparam logic BYP = (BYPASS != 0);

    // Qualified write/mark strobes. Gating with reset keeps a write presented
    // during reset from leaking out through the bypass path.
    logic w0_ok;
    logic w1_ok;
    logic mk_ok;

    assign w0_ok = rst_n_i && we0_i  && in_range(32'(widx0_i),    NUM_REGS, ZR0);
    assign w1_ok = rst_n_i && we1_i  && in_range(32'(widx1_i),    NUM_REGS, ZR0);
    assign mk_ok = rst_n_i && mark_i && in_range(32'(mark_idx_i), NUM_REGS, ZR0);

    // Storage array; per-entry compare avoids indexing past NUM_REGS when it
    // is not a power of two.
    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w0_ok && (widx0_i == ADDR_W'(i))) begin
                    regs[i] <= wdata0_i;
                end else if (w1_ok && (widx1_i == ADDR_W'(i))) begin
                    regs[i] <= wdata1_i;
                end
            end
        end
    end

    logic collision_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= w0_ok && w1_ok && (widx0_i == widx1_i);
        end
    end

    assign collision_o = collision_q;

    cpu_regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .set_i      (mk_ok),
        .set_idx_i  (mark_idx_i),
        .clr_i      (w1_ok),
        .clr_idx_i  (widx1_i),
        .busy_vec_o (busy_vec_o)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic              ok;
        logic              hit0;
        logic              hit1;
        logic              hitm;
        logic [DATA_W-1:0] stored;
        logic              pend;
        logic [DATA_W-1:0] data;

        assign idx  = rd_idx_i[k*ADDR_W +: ADDR_W];
        assign ok   = in_range(32'(idx), NUM_REGS, ZR0);
        assign hit0 = BYP && w0_ok && (widx0_i == idx);
        assign hit1 = BYP && w1_ok && (widx1_i == idx);
        assign hitm = mk_ok && (mark_idx_i == idx);

        always_comb begin
            stored = '0;
            pend   = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx == ADDR_W'(i)) begin
                    stored = regs[i];
                    pend   = busy_vec_o[i];
                end
            end
        end

        // Port 0 bypass takes priority, matching the write arbitration.
        always_comb begin
            if (!ok) begin
                data = '0;
            end else if (hit0) begin
                data = wdata0_i;
            end else if (hit1) begin
                data = wdata1_i;
            end else begin
                data = stored;
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = data;
        // A load landing this cycle releases the hazard early unless a new
        // load to the same register is being marked at the same time.
        assign rd_busy_o[k] = ok && pend && !(hit1 && !hitm);
    end

endmodule

// File: tb/tb_cpu_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_cpu_regfile_mp
// Directed bench for cpu_regfile_mp. Three instances share one stimulus:
// default (BYPASS=1, 16 regs), BYPASS=0, and NUM_REGS=12.
// -----------------------------------------------------------------------------
module tb_cpu_regfile_mp;
    import cpu_regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we0;
    regidx_t     widx0;
    logic [31:0] wdata0;
    logic        we1;
    regidx_t     widx1;
    logic [31:0] wdata1;
    logic        mark;
    regidx_t     mark_idx;
    logic [7:0]  rd_idx;

    logic [63:0] rdata_a, rdata_b, rdata_c;
    logic [1:0]  busy_a, busy_b, busy_c;
    logic [15:0] bvec_a, bvec_b;
    logic [11:0] bvec_c;
    logic        coll_a, coll_b, coll_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_regfile_mp #(.BYPASS(1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .we0_i(we0), .widx0_i(widx0), .wdata0_i(wdata0),
        .we1_i(we1), .widx1_i(widx1), .wdata1_i(wdata1),
        .mark_i(mark), .mark_idx_i(mark_idx), .rd_idx_i(rd_idx),
        .rd_data_o(rdata_a), .rd_busy_o(busy_a), .busy_vec_o(bvec_a),
        .collision_o(coll_a)
    );

    cpu_regfile_mp #(.BYPASS(0)) u_nb (
        .clk_i(clk), .rst_n_i(rst_n),
        .we0_i(we0), .widx0_i(widx0), .wdata0_i(wdata0),
        .we1_i(we1), .widx1_i(widx1), .wdata1_i(wdata1),
        .mark_i(mark), .mark_idx_i(mark_idx), .rd_idx_i(rd_idx),
        .rd_data_o(rdata_b), .rd_busy_o(busy_b), .busy_vec_o(bvec_b),
        .collision_o(coll_b)
    );

    cpu_regfile_mp #(.NUM_REGS(12)) u_12 (
        .clk_i(clk), .rst_n_i(rst_n),
        .we0_i(we0), .widx0_i(widx0), .wdata0_i(wdata0),
        .we1_i(we1), .widx1_i(widx1), .wdata1_i(wdata1),
        .mark_i(mark), .mark_idx_i(mark_idx), .rd_idx_i(rd_idx),
        .rd_data_o(rdata_c), .rd_busy_o(busy_c), .busy_vec_o(bvec_c),
        .collision_o(coll_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; mark = 1'b0;
    endtask

    task automatic rd(input regidx_t p0, input regidx_t p1);
        rd_idx = {p1, p0};
    endtask

    initial begin
        rst_n = 1'b0;
        we0 = 1'b0; widx0 = '0; wdata0 = '0;
        we1 = 1'b0; widx1 = '0; wdata1 = '0;
        mark = 1'b0; mark_idx = '0; rd_idx = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reset state: every register reads zero, nothing pending
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 4'(15 - i));
            #1;
            check($sformatf("rst_rd0_r%0d", i), rdata_a[31:0], 64'h0);
            check($sformatf("rst_rd1_r%0d", 15 - i), rdata_a[63:32], 64'h0);
            check($sformatf("rst_busy_%0d", i), busy_a, 64'h0);
        end
        check("rst_bvec", bvec_a, 64'h0);
        check("rst_coll", coll_a, 64'h0);

        // Two writes to different registers in one cycle
        we0 = 1'b1; widx0 = 4'd3; wdata0 = 32'hDEADBEEF;
        we1 = 1'b1; widx1 = 4'd5; wdata1 = 32'h12345678;
        tick();
        idle();
        rd(4'd3, 4'd5);
        #1;
        check("wr_r3", rdata_a[31:0], 64'hDEADBEEF);
        check("wr_r5", rdata_a[63:32], 64'h12345678);
        check("wr_nocoll", coll_a, 64'h0);

        // Both ports on r7: port 0 wins, collision pulses once
        we0 = 1'b1; widx0 = 4'd7; wdata0 = 32'h1111;
        we1 = 1'b1; widx1 = 4'd7; wdata1 = 32'h2222;
        rd(4'd7, 4'd7);
        #1;
        check("byp_clash_r7", rdata_a[31:0], 64'h1111);
        check("nobyp_clash_r7", rdata_b[31:0], 64'h0);
        tick();
        idle();
        #1;
        check("clash_r7", rdata_a[31:0], 64'h1111);
        check("coll_pulse", coll_a, 64'h1);
        tick();
        check("coll_drop", coll_a, 64'h0);

        // Same-cycle bypass vs stored contents
        we0 = 1'b1; widx0 = 4'd2; wdata0 = 32'hA5A5A5A5;
        we1 = 1'b1; widx1 = 4'd6; wdata1 = 32'hCAFE;
        rd(4'd2, 4'd6);
        #1;
        check("byp_r2", rdata_a[31:0], 64'hA5A5A5A5);
        check("byp_r6_p1", rdata_a[63:32], 64'hCAFE);
        check("nobyp_r2_old", rdata_b[31:0], 64'h0);
        check("nobyp_r6_old", rdata_b[63:32], 64'h0);
        tick();
        idle();
        #1;
        check("nobyp_r2_new", rdata_b[31:0], 64'hA5A5A5A5);
        check("nobyp_r6_new", rdata_b[63:32], 64'hCAFE);

        // Scoreboard: mark, release, bypassed release, set-beats-clear
        mark = 1'b1; mark_idx = 4'd4;
        tick();
        idle();
        rd(4'd4, 4'd0);
        #1;
        check("mark_bvec", bvec_a, 64'h0010);
        check("mark_rdbusy", busy_a, 64'h1);
        we1 = 1'b1; widx1 = 4'd4; wdata1 = 32'h44;
        #1;
        check("clr_byp_busy", busy_a, 64'h0);
        check("clr_nobyp_busy", busy_b, 64'h1);
        tick();
        idle();
        check("clr_bvec", bvec_a, 64'h0);
        mark = 1'b1; mark_idx = 4'd4;
        tick();
        check("remark_bvec", bvec_a, 64'h0010);
        we1 = 1'b1; widx1 = 4'd4; wdata1 = 32'h45;
        #1;
        check("setclr_rdbusy", busy_a, 64'h1);
        tick();
        idle();
        check("setclr_bvec", bvec_a, 64'h0010);
        we0 = 1'b1; widx0 = 4'd4; wdata0 = 32'h46;
        tick();
        idle();
        check("we0_keeps_busy", bvec_a, 64'h0010);
        we1 = 1'b1; widx1 = 4'd4; wdata1 = 32'h47;
        tick();
        idle();
        check("final_clr_bvec", bvec_a, 64'h0);

        // Out-of-range index on the 12-entry file
        we0 = 1'b1; widx0 = 4'd13; wdata0 = 32'hBAD;
        mark = 1'b1; mark_idx = 4'd13;
        we1 = 1'b1; widx1 = 4'd11; wdata1 = 32'hB11;
        tick();
        idle();
        rd(4'd13, 4'd11);
        #1;
        check("oor_rd13", rdata_c[31:0], 64'h0);
        check("oor_r11", rdata_c[63:32], 64'hB11);
        check("oor_busy", busy_c, 64'h0);
        check("oor_bvec", bvec_c, 64'h0);
        check("r13_in16", rdata_a[31:0], 64'hBAD);
        check("r13_bvec16", bvec_a, 64'h2000);

        // Asynchronous reset between edges
        we0 = 1'b1; widx0 = 4'd9; wdata0 = 32'h55;
        tick();
        idle();
        rd(4'd9, 4'd9);
        #1;
        check("r9_written", rdata_a[31:0], 64'h55);
        we0 = 1'b1; widx0 = 4'd9; wdata0 = 32'h77;
        we1 = 1'b1; widx1 = 4'd9; wdata1 = 32'h66;
        mark = 1'b1; mark_idx = 4'd9;
        tick();
        check("pre_rst_coll", coll_a, 64'h1);
        check("pre_rst_bvec", bvec_a, 64'h2200);
        check("pre_rst_r9", rdata_b[31:0], 64'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_coll", coll_a, 64'h0);
        check("arst_bvec", bvec_a, 64'h0);
        check("arst_rd_byp", rdata_a, 64'h0);
        check("arst_rd_nobyp", rdata_b, 64'h0);
        check("arst_rdbusy", busy_a, 64'h0);
        tick();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd(4'd9, 4'd3);
        #1;
        check("post_rst_r9", rdata_a[31:0], 64'h0);
        check("post_rst_r3", rdata_a[63:32], 64'h0);
        check("post_rst_r9_nb", rdata_b[31:0], 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
